sprite_bounce_engine: RTL and testbench

Parametrised successor of the single-counter LCD demo top: animates N_SPRITES independent rectangles at a fixed frame rate. Each sprite bounces off the screen edges, and a saturating bounce score is kept. The block renders one pixel colour per (x, y) query from the LCD scanner. It sits between the board key inputs, the LCD pixel interface and the seven-segment/LED outputs, and owns its own frame strobe.

---
 rtl/sprite_bounce_pkg.sv | 44 ++++
 rtl/sprite_bounce_engine_if.sv | 11 +
 rtl/sprite_bounce_engine_axis.sv | 67 ++++++
 rtl/sprite_bounce_engine.sv | 156 +++++++++++++++
 tb/tb_sprite_bounce_engine.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_bounce_pkg.sv
// Shared types and constants for the bouncing-sprite LCD engine: colour and
// velocity structs, the sprite palette and a small popcount helper.
package sprite_bounce_pkg;

    localparam int POS_W = 9;
    localparam int VEL_W = 5;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic signed [VEL_W-1:0] dx;
        logic signed [VEL_W-1:0] dy;
    } vel_t;

    localparam rgb565_t BLACK = 16'h0000;
    localparam rgb565_t WHITE = 16'hFFFF;

    localparam rgb565_t PALETTE [0:7] = '{
        16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
        16'h07FF, 16'hF81F, 16'hFC00, 16'h8410
    };

    // Sprite i starts moving right by i+1 and down by 1 pixel per frame.
    function automatic vel_t reset_vel(input int idx);
        vel_t v;
        v.dx = VEL_W'(idx + 1);
        v.dy = VEL_W'(1);
        return v;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sprite_bounce_engine_if.sv
// Pixel query bus between the LCD scanner (master) and the sprite engine.
interface sprite_bounce_engine_if;
    logic [8:0] x;
    logic [8:0] y;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;

    modport master (output x, y, input red, green, blue);
    modport slave  (input x, y, output red, green, blue);
endinterface

// File: rtl/sprite_bounce_engine_axis.sv
// bounce_axis: one coordinate of one sprite, stepping by its velocity each
// enabled frame and reflecting off 0 / LIMIT.
module bounce_axis
    import sprite_bounce_pkg::*;
#(
    parameter int LIMIT   = 448,
    parameter int POS_RST = 0,
    parameter int VEL_RST = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             step_en,
    input  logic             double_speed,
    output logic [POS_W-1:0] pos,
    output logic             reflected
);

    localparam int CAND_W = POS_W + 3;
    localparam logic signed [CAND_W-1:0] LIMIT_C = CAND_W'(LIMIT);

    logic        [POS_W-1:0]  pos_r;
    logic        [POS_W-1:0]  pos_next_s;
    logic signed [VEL_W-1:0]  vel_r;
    logic signed [VEL_W-1:0]  vel_next_s;
    logic signed [CAND_W-1:0] vel_ext_s;
    logic signed [CAND_W-1:0] step_s;
    logic signed [CAND_W-1:0] cand_s;

    // Candidate position in a widened signed range, then clamp and reflect.
    always_comb begin
        vel_ext_s  = {{(CAND_W-VEL_W){vel_r[VEL_W-1]}}, vel_r};
        step_s     = double_speed ? {vel_ext_s[CAND_W-2:0], 1'b0} : vel_ext_s;
        cand_s     = $signed({3'b000, pos_r}) + step_s;
        pos_next_s = pos_r;
        vel_next_s = vel_r;
        reflected  = 1'b0;
        if (cand_s[CAND_W-1]) begin
            pos_next_s = '0;
            vel_next_s = -vel_r;
            reflected  = 1'b1;
        end else if (cand_s > LIMIT_C) begin
            pos_next_s = POS_W'(LIMIT);
            vel_next_s = -vel_r;
            reflected  = 1'b1;
        end else begin
            pos_next_s = cand_s[POS_W-1:0];
        end
    end

    // Position/velocity state; restart overrides a frame step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_r <= POS_W'(POS_RST);
            vel_r <= VEL_W'(VEL_RST);
        end else if (restart) begin
            pos_r <= POS_W'(POS_RST);
            vel_r <= VEL_W'(VEL_RST);
        end else if (step_en) begin
            pos_r <= pos_next_s;
            vel_r <= vel_next_s;
        end
    end

    assign pos = pos_r;

endmodule

// File: rtl/sprite_bounce_engine.sv
// Animates N_SPRITES bouncing rectangles at FRAME_HZ, counts edge bounces
// into a saturating score and renders one RGB565 pixel per (x, y) query.
module sprite_bounce_engine
    import sprite_bounce_pkg::*;
#(
    parameter int CLK_MHZ   = 27,
    parameter int FRAME_HZ  = 30,
    parameter int N_SPRITES = 4,
    parameter int SCREEN_W  = 480,
    parameter int SCREEN_H  = 272,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 24
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             key,
    sprite_bounce_engine_if.slave  pix,
    output logic [7:0]             led,
    output logic [31:0]            number,
    output logic                   frame_tick
);

    localparam int PERIOD = CLK_MHZ * 1000000 / FRAME_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [9:0] SPR_W_C = 10'(SPRITE_W);
    localparam logic [9:0] SPR_H_C = 10'(SPRITE_H);

    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_next_s;
    logic                 tick_r;
    logic [15:0]          score_r;
    logic [15:0]          score_next_s;
    logic [16:0]          score_sum_s;
    logic [POS_W-1:0]     px_s [N_SPRITES];
    logic [POS_W-1:0]     py_s [N_SPRITES];
    logic [N_SPRITES-1:0] refl_x_s;
    logic [N_SPRITES-1:0] refl_y_s;
    logic [N_SPRITES-1:0] hit_s;
    logic [2:0]           owner_s;
    logic [3:0]           hit_cnt_s;
    rgb565_t              rgb_s;
    logic                 step_en_s;
    logic                 restart_s;
    logic                 unused_key_s;

    assign restart_s    = key[2];
    assign step_en_s    = tick_r & ~key[0];
    assign unused_key_s = ^key[7:3];

    // Frame counter wrap; the strobe is registered so it is high while cnt == P-1.
    always_comb begin
        if (cnt_r == CNT_W'(PERIOD - 1)) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Frame strobe counter and its registered tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_W'(PERIOD - 1));
        end
    end

    for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
        localparam vel_t RST_VEL = reset_vel(gi);

        bounce_axis #(
            .LIMIT   (SCREEN_W - SPRITE_W),
            .POS_RST (gi * (SPRITE_W + 8)),
            .VEL_RST (int'(RST_VEL.dx))
        ) u_x (
            .clock        (clock),
            .reset_n      (reset_n),
            .restart      (restart_s),
            .step_en      (step_en_s),
            .double_speed (key[1]),
            .pos          (px_s[gi]),
            .reflected    (refl_x_s[gi])
        );

        bounce_axis #(
            .LIMIT   (SCREEN_H - SPRITE_H),
            .POS_RST (gi * (SPRITE_H + 8)),
            .VEL_RST (int'(RST_VEL.dy))
        ) u_y (
            .clock        (clock),
            .reset_n      (reset_n),
            .restart      (restart_s),
            .step_en      (step_en_s),
            .double_speed (key[1]),
            .pos          (py_s[gi]),
            .reflected    (refl_y_s[gi])
        );
    end

    // A corner hit still counts once per sprite; the sum saturates at 16'hFFFF.
    always_comb begin
        score_sum_s = {1'b0, score_r} + {13'd0, popcount8(8'(refl_x_s | refl_y_s))};
        if (score_sum_s[16]) begin
            score_next_s = 16'hFFFF;
        end else begin
            score_next_s = score_sum_s[15:0];
        end
    end

    // Score register; a restarting frame does not score.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            score_r <= 16'd0;
        end else if (step_en_s && !restart_s) begin
            score_r <= score_next_s;
        end
    end

    assign led        = score_r[7:0];
    assign number     = {16'd0, score_r};
    assign frame_tick = tick_r;

    // Pixel render: overlaps go white, single hits take the sprite colour.
    always_comb begin
        hit_s   = '0;
        owner_s = 3'd0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (({1'b0, pix.x} >= {1'b0, px_s[i]}) &&
                ({1'b0, pix.x} <  ({1'b0, px_s[i]} + SPR_W_C)) &&
                ({1'b0, pix.y} >= {1'b0, py_s[i]}) &&
                ({1'b0, pix.y} <  ({1'b0, py_s[i]} + SPR_H_C))) begin
                hit_s[i] = 1'b1;
                owner_s  = 3'(i);
            end else begin
                hit_s[i] = 1'b0;
            end
        end
        hit_cnt_s = popcount8(8'(hit_s));
        if (({1'b0, pix.x} >= 10'(SCREEN_W)) || ({1'b0, pix.y} >= 10'(SCREEN_H))) begin
            rgb_s = BLACK;
        end else if (hit_cnt_s == 4'd0) begin
            rgb_s = BLACK;
        end else if (hit_cnt_s == 4'd1) begin
            rgb_s = PALETTE[owner_s];
        end else begin
            rgb_s = WHITE;
        end
    end

    assign pix.red   = rgb_s.r;
    assign pix.green = rgb_s.g;
    assign pix.blue  = rgb_s.b;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Directed bench for sprite_bounce_engine on a 64x48 screen with two 8x8
// sprites and a 4-cycle frame period.
`timescale 1ns/1ps
module tb_sprite_bounce_engine;

    localparam logic [15:0] PAL_EXP [2] = '{16'hF800, 16'h07E0};

    logic        clock;
    logic        reset_n;
    logic [7:0]  key;
    logic [7:0]  led;
    logic [31:0] number;
    logic        frame_tick;
    int          checks_cnt;
    int          errors_cnt;

    sprite_bounce_engine_if pix ();

    sprite_bounce_engine #(
        .CLK_MHZ   (1),
        .FRAME_HZ  (250000),
        .N_SPRITES (2),
        .SCREEN_W  (64),
        .SCREEN_H  (48),
        .SPRITE_W  (8),
        .SPRITE_H  (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key        (key),
        .pix        (pix.slave),
        .led        (led),
        .number     (number),
        .frame_tick (frame_tick)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_pixel(input string tag, input int px, input int py, input logic [15:0] exp);
        pix.x = 9'(px);
        pix.y = 9'(py);
        #1;
        check_value(tag, {16'd0, pix.red, pix.green, pix.blue}, {16'd0, exp});
    endtask

    // Top-left corner in sprite colour, pixels just left of and above it black.
    task automatic probe_sprite(input int idx, input int px, input int py);
        check_pixel($sformatf("s%0d_corner_%0d_%0d", idx, px, py), px, py, PAL_EXP[idx]);
        check_pixel($sformatf("s%0d_left_%0d_%0d", idx, px, py), px - 1, py, 16'h0000);
        check_pixel($sformatf("s%0d_above_%0d_%0d", idx, px, py), px, py - 1, 16'h0000);
    endtask

    // Starts on a negedge; returns on the negedge after the next update edge.
    task automatic tick_wait();
        int guard;
        guard = 0;
        while (frame_tick !== 1'b1 && guard < 16) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 16) check_value("tick_timeout", 32'd0, 32'd1);
        @(negedge clock);
    endtask

    initial begin
        int guard;
        checks_cnt = 0;
        errors_cnt = 0;
        reset_n    = 1'b0;
        key        = 8'h00;
        pix.x      = 9'd0;
        pix.y      = 9'd0;
        repeat (3) @(negedge clock);
        check_value("rst_led", 32'(led), 32'd0);
        check_value("rst_number", number, 32'd0);
        check_value("rst_tick", 32'(frame_tick), 32'd0);
        probe_sprite(0, 0, 0);
        probe_sprite(1, 16, 16);

        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            check_value($sformatf("tick_cycle_%0d", k), 32'(frame_tick), 32'((k % 4) == 3));
            if (k == 4) begin
                probe_sprite(0, 1, 1);
                probe_sprite(1, 18, 17);
            end
            if (k == 8) begin
                probe_sprite(0, 2, 2);
                probe_sprite(1, 20, 18);
            end
        end

        // Sprite 1 reaches the right edge at frame 20 and reflects at 21.
        for (int t = 4; t <= 22; t++) begin
            tick_wait();
            if (t == 20) begin
                probe_sprite(1, 56, 36);
                check_value("score_before_bounce", number, 32'd0);
            end
            if (t == 21) begin
                probe_sprite(1, 56, 37);
                check_value("bounce_led", 32'(led), 32'd1);
                check_value("bounce_number", number, 32'd1);
            end
        end
        probe_sprite(0, 22, 22);
        probe_sprite(1, 54, 38);

        key = 8'h01;
        for (int p = 0; p < 5; p++) begin
            repeat (3) @(negedge clock);
            check_value($sformatf("pause_tick_%0d", p), 32'(frame_tick), 32'd1);
            @(negedge clock);
        end
        probe_sprite(0, 22, 22);
        probe_sprite(1, 54, 38);
        check_value("pause_score", number, 32'd1);
        key = 8'h00;

        guard = 0;
        while (frame_tick !== 1'b1 && guard < 16) begin
            @(negedge clock);
            guard++;
        end
        check_value("restart_on_tick_found", 32'(frame_tick), 32'd1);
        key = 8'h04;
        @(negedge clock);
        key = 8'h00;
        probe_sprite(0, 0, 0);
        probe_sprite(1, 16, 16);
        check_value("restart_keeps_score", number, 32'd1);
        tick_wait();
        probe_sprite(0, 1, 1);
        probe_sprite(1, 18, 17);

        key = 8'h02;
        tick_wait();
        probe_sprite(0, 3, 3);
        probe_sprite(1, 22, 19);
        tick_wait();
        probe_sprite(0, 5, 5);
        probe_sprite(1, 26, 21);
        key = 8'h04;
        @(negedge clock);
        key = 8'h00;

        for (int t = 1; t <= 31; t++) begin
            tick_wait();
            if (t == 21) begin
                probe_sprite(1, 56, 37);
                check_value("second_bounce", number, 32'd2);
            end
            if (t == 25) begin
                probe_sprite(1, 48, 40);
                check_value("bottom_bounce", number, 32'd3);
            end
        end

        // Frame 31: sprite 0 at (31,31), sprite 1 at (36,34).
        check_pixel("overlap_white", 36, 34, 16'hFFFF);
        check_pixel("only_s0", 31, 31, PAL_EXP[0]);
        check_pixel("only_s0_edge", 35, 34, PAL_EXP[0]);
        check_pixel("only_s1", 43, 41, PAL_EXP[1]);
        check_pixel("offscreen_x70", 70, 34, 16'h0000);

        force dut.score_r = 16'hFFFF;
        @(negedge clock);
        release dut.score_r;
        #1;
        check_value("forced_led", 32'(led), 32'h000000FF);
        for (int t = 32; t <= 41; t++) begin
            tick_wait();
            if (t == 40) check_value("hold_ffff", number, 32'h0000FFFF);
        end
        probe_sprite(0, 41, 40);
        check_value("saturate_number", number, 32'h0000FFFF);
        check_value("saturate_led", 32'(led), 32'h000000FF);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
